// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the ALU opcode map and the state encoding
// used by the multi-cycle multiply/divide unit.
package cpu_pkg;

   localparam int WORD = 32;

   localparam logic [4:0] LD_OPCODE   = 5'b00000;
   localparam logic [4:0] LDI_OPCODE  = 5'b00001;
   localparam logic [4:0] ST_OPCODE   = 5'b00010;
   localparam logic [4:0] ADD_OPCODE  = 5'b00011;
   localparam logic [4:0] SUB_OPCODE  = 5'b00100;
   localparam logic [4:0] SHR_OPCODE  = 5'b00101;
   localparam logic [4:0] SHRA_OPCODE = 5'b00110;
   localparam logic [4:0] SHL_OPCODE  = 5'b00111;
   localparam logic [4:0] ROR_OPCODE  = 5'b01000;
   localparam logic [4:0] ROL_OPCODE  = 5'b01001;
   localparam logic [4:0] AND_OPCODE  = 5'b01010;
   localparam logic [4:0] OR_OPCODE   = 5'b01011;
   localparam logic [4:0] ADDI_OPCODE = 5'b01100;
   localparam logic [4:0] ANDI_OPCODE = 5'b01101;
   localparam logic [4:0] ORI_OPCODE  = 5'b01110;
   localparam logic [4:0] MUL_OPCODE  = 5'b01111;
   localparam logic [4:0] DIV_OPCODE  = 5'b10000;
   localparam logic [4:0] NEG_OPCODE  = 5'b10001;
   localparam logic [4:0] NOT_OPCODE  = 5'b10010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } md_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/busy/done handshake plus operand and result buses between the
// control unit (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(parameter int WIDTH = 32);

   logic                 start;
   logic [4:0]           op_code;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   c;
   logic                 busy;
   logic                 done;

   modport master (output start, op_code, a, b, input c, busy, done);
   modport slave  (input start, op_code, a, b, output c, busy, done);

endinterface

// File: rtl/mul_div_unit_nr_div_step.sv
// One combinational non-restoring division iteration on {R,Q}, where R is
// a signed partial remainder one bit wider than the unsigned divisor.
module nr_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0]  rq,
   input  logic [WIDTH-1:0]  divisor,
   output logic [2*WIDTH:0]  rq_next
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] r_new;

   // The sign of R before the shift picks subtract or add; the new quotient
   // bit is set when the updated remainder is non-negative.
   always_comb begin
      r_shift = rq[2*WIDTH-1:WIDTH-1];
      if (rq[2*WIDTH]) begin
         r_new = r_shift + {1'b0, divisor};
      end else begin
         r_new = r_shift - {1'b0, divisor};
      end
      rq_next = {r_new, rq[WIDTH-2:0], ~r_new[WIDTH]};
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit
// producing a registered {HI, LO} result under a start/busy/done handshake.
module mul_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          clear_n,
   mul_div_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   md_state_t            state, state_n;
   logic [CW-1:0]        count, count_n;
   logic [WIDTH-1:0]     mcand, mcand_n;
   logic [WIDTH:0]       upper, upper_n;
   logic [WIDTH-1:0]     q, q_n;
   logic                 qm1, qm1_n;
   logic                 neg_q, neg_q_n;
   logic                 neg_r, neg_r_n;
   logic [2*WIDTH-1:0]   c_reg, c_n;
   logic                 busy_r, done_r;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       booth_sum;
   logic [2*WIDTH:0]     div_next;
   logic [WIDTH-1:0]     r_fix, r_fin, q_fin;

   nr_div_step #(.WIDTH(WIDTH)) u_step (
      .rq      ({upper, q}),
      .divisor (mcand),
      .rq_next (div_next)
   );

   // Next-state and datapath update; for a divide, mcand holds |divisor|,
   // upper holds the signed remainder R and q the quotient.
   always_comb begin
      state_n   = state;
      count_n   = count;
      mcand_n   = mcand;
      upper_n   = upper;
      q_n       = q;
      qm1_n     = qm1;
      neg_q_n   = neg_q;
      neg_r_n   = neg_r;
      c_n       = c_reg;
      a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
      booth_sum = upper;
      r_fix     = upper[WIDTH-1:0];
      r_fin     = '0;
      q_fin     = '0;

      case (state)
         ST_IDLE: begin
            if (bus.start && bus.op_code == MUL_OPCODE) begin
               state_n = ST_MUL;
               count_n = '0;
               mcand_n = bus.a;
               upper_n = '0;
               q_n     = bus.b;
               qm1_n   = 1'b0;
            end else if (bus.start && bus.op_code == DIV_OPCODE) begin
               if (bus.b == '0) begin
                  state_n = ST_DONE;
                  c_n     = {bus.a, {WIDTH{1'b1}}};
               end else begin
                  state_n = ST_DIV;
                  count_n = '0;
                  mcand_n = b_mag;
                  upper_n = '0;
                  q_n     = a_mag;
                  neg_q_n = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  neg_r_n = bus.a[WIDTH-1];
               end
            end
         end

         ST_MUL: begin
            case ({q[0], qm1})
               2'b01:   booth_sum = upper + {mcand[WIDTH-1], mcand};
               2'b10:   booth_sum = upper - {mcand[WIDTH-1], mcand};
               default: booth_sum = upper;
            endcase
            {upper_n, q_n, qm1_n} = {booth_sum[WIDTH], booth_sum, q};
            if (count == CW'(WIDTH-1)) begin
               state_n = ST_DONE;
               c_n     = {upper_n[WIDTH-1:0], q_n};
            end else begin
               count_n = count + CW'(1);
            end
         end

         ST_DIV: begin
            {upper_n, q_n} = div_next;
            if (count == CW'(WIDTH-1)) begin
               state_n = ST_FIX;
            end else begin
               count_n = count + CW'(1);
            end
         end

         ST_FIX: begin
            r_fix   = upper[WIDTH] ? upper[WIDTH-1:0] + mcand : upper[WIDTH-1:0];
            q_fin   = neg_q ? -q : q;
            r_fin   = neg_r ? -r_fix : r_fix;
            c_n     = {r_fin, q_fin};
            state_n = ST_DONE;
         end

         ST_DONE: begin
            state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // busy and done are registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state  <= ST_IDLE;
         count  <= '0;
         mcand  <= '0;
         upper  <= '0;
         q      <= '0;
         qm1    <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         c_reg  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         mcand  <= mcand_n;
         upper  <= upper_n;
         q      <= q_n;
         qm1    <= qm1_n;
         neg_q  <= neg_q_n;
         neg_r  <= neg_r_n;
         c_reg  <= c_n;
         busy_r <= (state_n != ST_IDLE);
         done_r <= (state_n == ST_DONE);
      end
   end

   assign bus.c    = c_reg;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
